// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, parity mode and the receiver state encoding.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_STOP_BITS  = 2;

  // 0 selects even parity: the parity bit equals the XOR of the payload bits.
  localparam logic PARITY_MODE_ODD = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input.
// Both flops reset to RESET_VAL so an idle line never looks like an edge.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampled UART receiver: start, LSB-first payload, parity, 1-2 stop bits.
// Delivers every frame with error flags; an unacknowledged frame that gets replaced raises overrunError.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int STOP_BITS  = DEFAULT_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 serialIn,
  input  logic                 dataAck,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  output logic                 parityError,
  output logic                 framingError,
  output logic                 overrunError,
  output logic [2:0]           state_dbg
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic rx_s;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serialIn),
    .q     (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop_err_q, stop_err_d;
  logic                 frame_done;

  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    stop_err_d = stop_err_q;
    frame_done = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end
        end
        ST_START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (tick_cnt_q == HALF_LAST) begin
            state_d    = rx_s ? ST_IDLE : ST_DATA;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = DATA_BITS'({rx_s, shift_q} >> 1);
            if (bit_cnt_q == DATA_LAST) begin
              state_d   = ST_PARITY;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        ST_PARITY: begin
          if (tick_cnt_q == FULL_LAST) begin
            state_d    = ST_STOP;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            par_bit_d  = rx_s;
            stop_err_d = 1'b0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        ST_STOP: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            stop_err_d = stop_err_q | ~rx_s;
            if (bit_cnt_q == STOP_LAST) begin
              state_d    = ST_IDLE;
              bit_cnt_d  = '0;
              frame_done = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      endcase
    end
  end

  // Handshake: dataValid stays high from frame completion until a cycle with dataAck high;
  // that cycle clears valid and all flags. A completing frame takes priority and, if the
  // previous frame was not acknowledged in that same cycle, marks overrun.
  always_comb begin
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overrun_d     = overrun_q;

    if (frame_done) begin
      data_out_d    = shift_q;
      data_valid_d  = 1'b1;
      parity_err_d  = ((^shift_q) ^ PARITY_MODE_ODD) != par_bit_q;
      framing_err_d = stop_err_d;
      overrun_d     = data_valid_q & ~dataAck;
    end else if (dataAck && data_valid_q) begin
      data_valid_d  = 1'b0;
      parity_err_d  = 1'b0;
      framing_err_d = 1'b0;
      overrun_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_bit_q     <= 1'b0;
      stop_err_q    <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_bit_q     <= par_bit_d;
      stop_err_q    <= stop_err_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign dataOut      = data_out_q;
  assign dataValid    = data_valid_q;
  assign parityError  = parity_err_q;
  assign framingError = framing_err_q;
  assign overrunError = overrun_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: drives whole serial frames tick by tick and compares the delivered
// payload and flags with a frame-level model of the receiver's consumer interface.
module tb_uart_receiver;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int SB = 2;
  localparam int VW = DB + 4;
  // Clocks from driving the start bit to dataValid, one tick per clock:
  // 2 synchronizer flops + 1 idle detect + half a bit + the remaining bits up to the last stop mid-point.
  localparam int LAT = 3 + OS / 2 + OS * (DB + 1 + SB);

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          serialIn;
  logic          dataAck;
  logic [DB-1:0] dataOut;
  logic          dataValid;
  logic          parityError;
  logic          framingError;
  logic          overrunError;
  logic [2:0]    state_dbg;

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .serialIn     (serialIn),
    .dataAck      (dataAck),
    .dataOut      (dataOut),
    .dataValid    (dataValid),
    .parityError  (parityError),
    .framingError (framingError),
    .overrunError (overrunError),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tick_period = 1;
  initial begin : tick_gen
    int c;
    c = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (c >= tick_period) c = 0;
      tick = (c == 0);
      c++;
    end
  end

  int   rise_cyc = -1;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (dataValid === 1'b1 && prev_valid !== 1'b1) rise_cyc <= cyc;
    prev_valid <= dataValid;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- reference model / scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int start_cyc = 0;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_v;
  logic [DB-1:0] m_data;
  logic          m_valid, m_par, m_frm, m_ovr;

  task model_push();
    exp_q.push_back({m_valid, m_par, m_frm, m_ovr, m_data});
  endtask

  task model_reset();
    m_data = '0; m_valid = 1'b0; m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
    model_push();
  endtask

  task model_frame(input logic [DB-1:0] data, input logic par_bit,
                   input logic [SB-1:0] stops, input logic ack_same);
    m_ovr   = m_valid && !ack_same;
    m_data  = data;
    m_valid = 1'b1;
    m_par   = ((^data) != par_bit);
    m_frm   = (stops != {SB{1'b1}});
    model_push();
  endtask

  task model_ack();
    if (m_valid) begin
      m_valid = 1'b0; m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
    end
    model_push();
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {dataValid, parityError, framingError, overrunError, dataOut};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int k);
    int n;
    n = 0;
    while (n < k) begin
      @(posedge clk);
      if (tick) n++;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic par_bit,
                            input logic [SB-1:0] stops, input int max_bits);
    logic [DB+SB+1:0] bits;
    bits = {stops, par_bit, data, 1'b0};
    for (int i = 0; i < DB + SB + 2; i++) begin
      if (i >= max_bits) return;
      @(negedge clk);
      if (i == 0) start_cyc = cyc;
      serialIn = bits[i];
      wait_ticks(OS);
    end
    @(negedge clk);
    serialIn = 1'b1;
    wait_ticks(2 * OS);
    @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    dataAck = 1'b1;
    @(negedge clk);
    dataAck = 1'b0;
    model_ack();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    serialIn = 1'b1;
    dataAck = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL reset_state got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    tick_period = 1;
    repeat (4) @(negedge clk);
    send_frame(8'hA5, 1'b0, 2'b11, 99);
    model_frame(8'hA5, 1'b0, 2'b11, 1'b0);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL basic_a5 got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
    total_cnt++;
    if (rise_cyc - start_cyc !== LAT)
      $display("FAIL basic_latency got %0d want %0d", rise_cyc - start_cyc, LAT);
    else pass_cnt++;
    pulse_ack();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL basic_ack got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
  endtask

  task automatic test_parity_error();
    send_frame(8'h07, 1'b0, 2'b11, 99);
    model_frame(8'h07, 1'b0, 2'b11, 1'b0);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL parity_07 got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
    pulse_ack();
    void'(exp_q.pop_front());
  endtask

  task automatic test_framing_error();
    send_frame(8'h3C, 1'b0, 2'b01, 99);
    model_frame(8'h3C, 1'b0, 2'b01, 1'b0);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL framing_3c got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
    pulse_ack();
    void'(exp_q.pop_front());
  endtask

  task automatic test_glitch();
    @(negedge clk);
    serialIn = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    serialIn = 1'b1;
    wait_ticks(2 * OS);
    @(negedge clk);
    model_push();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL glitch_reject got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
    send_frame(8'h55, 1'b0, 2'b11, 99);
    model_frame(8'h55, 1'b0, 2'b11, 1'b0);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL glitch_then_55 got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
    pulse_ack();
    void'(exp_q.pop_front());
  endtask

  task automatic test_ack_idle();
    pulse_ack();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL ack_when_idle got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b0, 2'b11, 99);
    model_frame(8'h11, 1'b0, 2'b11, 1'b0);
    void'(exp_q.pop_front());
    send_frame(8'h22, 1'b0, 2'b11, 99);
    model_frame(8'h22, 1'b0, 2'b11, 1'b0);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL overrun_22 got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
    pulse_ack();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL overrun_ack got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_ack();
    tick_period = 1;
    send_frame(8'h11, 1'b0, 2'b11, 99);
    model_frame(8'h11, 1'b0, 2'b11, 1'b0);
    void'(exp_q.pop_front());
    fork
      send_frame(8'h5A, 1'b0, 2'b11, 99);
      begin
        @(negedge clk);
        repeat (LAT - 1) @(negedge clk);
        dataAck = 1'b1;
        @(negedge clk);
        dataAck = 1'b0;
      end
    join
    model_frame(8'h5A, 1'b0, 2'b11, 1'b1);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL ack_same_cycle got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
    pulse_ack();
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'hFF, 1'b1, 2'b11, 5);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL reset_mid_frame got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
    serialIn = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h81, 1'b0, 2'b11, 99);
    model_frame(8'h81, 1'b0, 2'b11, 1'b0);
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (dut_vec() !== exp_v) $display("FAIL after_reset_81 got %h want %h", dut_vec(), exp_v);
    else pass_cnt++;
    pulse_ack();
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    logic [DB-1:0] d;
    logic          p;
    logic [SB-1:0] s;
    for (int i = 0; i < 16; i++) begin
      tick_period = $urandom_range(1, 3);
      d = DB'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      s = ($urandom_range(0, 3) == 0) ? SB'($urandom_range(0, 2)) : {SB{1'b1}};
      send_frame(d, p, s, 99);
      model_frame(d, p, s, 1'b0);
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (dut_vec() !== exp_v) $display("FAIL random_frame_%0d got %h want %h", i, dut_vec(), exp_v);
      else pass_cnt++;
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (dut_vec() !== exp_v) $display("FAIL random_ack_%0d got %h want %h", i, dut_vec(), exp_v);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_framing_error();
    test_glitch();
    test_ack_idle();
    test_overrun();
    test_back_to_back_ack();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
